// File: rtl/chunk_fetcher.sv
// Producer side of the APU chunk valid/ack interface: fetches 64-bit sample words
// from a software-filled RAM ring and holds each one until the player acks it.
// Optional: define CHUNK_FETCHER_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module chunk_fetcher #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] buf_last,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [63:0]       ram_rdata,
  output logic [63:0]       chunk,
  output logic              chunk_valid,
  input  logic              chunk_ack,
  output logic              underrun
`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    HOLD
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ring_empty;
  logic              advance;
  logic              underrun_d;
  logic [ADDR_W-1:0] rd_ptr_next;

  // Equality only: a stray wr_ptr beyond buf_last just looks non-empty and the ring keeps wrapping.
  assign ring_empty  = (rd_ptr == wr_ptr);
  assign rd_ptr_next = (rd_ptr >= buf_last) ? '0 : rd_ptr + ADDR_W'(1);
  assign advance     = (state_q == CAPTURE) && !flush;
  assign underrun_d  = (state_q == HOLD) && chunk_ack && enable && ring_empty && !flush;

  assign ram_addr    = rd_ptr;
  assign ram_rd      = (state_q == READ);
  assign chunk_valid = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !ring_empty) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD: begin
        if (chunk_ack) begin
          state_d = (enable && !ring_empty) ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      chunk    <= '0;
      rd_ptr   <= '0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      underrun <= underrun_d;
      if (flush) begin
        rd_ptr <= '0;
      end else if (advance) begin
        chunk  <= ram_rdata;
        rd_ptr <= rd_ptr_next;
      end
    end
  end

`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      underrun_count <= '0;
    end else if (underrun_d && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chunk_fetcher.sv
// Directed bench for chunk_fetcher: a RAM model answers reads, expected chunks are
// queued when a fetch is triggered and popped when the DUT presents them.
module tb_chunk_fetcher;
  localparam int unsigned ADDR_W = 9;

  typedef struct {
    logic [63:0]       data;
    logic [ADDR_W-1:0] ptr;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              flush;
  logic [ADDR_W-1:0] buf_last;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [63:0]       ram_rdata;
  logic [63:0]       chunk;
  logic              chunk_valid;
  logic              chunk_ack;
  logic              underrun;
`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
  logic [15:0]       underrun_count;
`endif

  logic [63:0] mem [0:(1<<ADDR_W)-1];
  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [63:0] held;

  chunk_fetcher #(.ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .buf_last    (buf_last),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_rdata   (ram_rdata),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_ack   (chunk_ack),
    .underrun    (underrun)
`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous RAM: data for a strobed address appears the following cycle.
  always @(posedge clock) begin
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  function automatic logic [63:0] word(input int unsigned i);
    return 64'h0706050403020100 + 64'h0808080808080808 * i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned idx, input int unsigned nptr);
    exp_t e;
    e.data = word(idx);
    e.ptr  = ADDR_W'(nptr);
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_valid"}, chunk_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_chunk"}, chunk, e.data);
      chk({tag, "_rd_ptr"}, rd_ptr, e.ptr);
    end
  endtask

  // Ack the held chunk, expect the refetch strobe at 'addr', then the new chunk two cycles later.
  task automatic ack_and_fetch(input string tag, input int unsigned addr);
    chunk_ack = 1'b1;
    tick();
    chunk_ack = 1'b0;
    chk({tag, "_valid_drop"}, chunk_valid, 1'b0);
    chk({tag, "_ram_rd"}, ram_rd, 1'b1);
    chk({tag, "_ram_addr"}, ram_addr, addr);
    chk({tag, "_no_underrun"}, underrun, 1'b0);
    tick();
    chk({tag, "_capture_rd"}, ram_rd, 1'b0);
    tick();
    pop_chk(tag);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = word(i);
    ram_rdata = '0;
    reset     = 1'b1;
    enable    = 1'b0;
    flush     = 1'b0;
    chunk_ack = 1'b0;
    buf_last  = 9'd3;
    wr_ptr    = 9'd2;
    tick(); tick(); tick();

    chk("rst_chunk", chunk, 64'd0);
    chk("rst_valid", chunk_valid, 1'b0);
    chk("rst_ram_rd", ram_rd, 1'b0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_underrun", underrun, 1'b0);
`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
    chk("rst_ucount", underrun_count, 0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_no_read", ram_rd, 1'b0);

    // Basic fetch: enable at cycle 0.
    enable = 1'b1;
    push(0, 1);
    tick();
    chk("basic_ram_rd", ram_rd, 1'b1);
    chk("basic_ram_addr", ram_addr, 0);
    tick();
    chk("basic_c2_valid", chunk_valid, 1'b0);
    tick();
    pop_chk("basic");

    // Backpressure: 20 cycles without ack.
    held = chunk;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_chunk_stable", chunk, held);
      chk("bp_valid", chunk_valid, 1'b1);
      chk("bp_no_read", ram_rd, 1'b0);
    end
    push(1, 2);
    ack_and_fetch("bp", 1);

    // Underrun: ring now empty (rd_ptr=wr_ptr=2), ack while enabled.
    chunk_ack = 1'b1;
    tick();
    chunk_ack = 1'b0;
    chk("ur_pulse", underrun, 1'b1);
    chk("ur_valid", chunk_valid, 1'b0);
    chk("ur_no_read", ram_rd, 1'b0);
`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
    chk("ur_count", underrun_count, 1);
`endif
    tick();
    chk("ur_pulse_end", underrun, 1'b0);
    chk("ur_idle_no_read", ram_rd, 1'b0);
    wr_ptr = 9'd3;
    push(2, 3);
    tick();
    chk("resume_ram_rd", ram_rd, 1'b1);
    chk("resume_ram_addr", ram_addr, 2);
    tick();
    tick();
    pop_chk("resume");

    // Wrap: rd_ptr=3 with buf_last=3 goes to 0, then on to 1.
    wr_ptr = 9'd1;
    push(3, 0);
    ack_and_fetch("wrap3", 3);
    push(0, 1);
    ack_and_fetch("wrap0", 0);

    // Flush during READ with rd_ptr=2.
    wr_ptr = 9'd3;
    push(1, 2);
    ack_and_fetch("pre_flush", 1);
    chunk_ack = 1'b1;
    tick();
    chunk_ack = 1'b0;
    chk("fl_read_cycle", ram_rd, 1'b1);
    chk("fl_read_addr", ram_addr, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", chunk_valid, 1'b0);
    chk("fl_rd_ptr", rd_ptr, 0);
    chk("fl_idle_no_read", ram_rd, 1'b0);
    push(0, 1);
    tick();
    chk("fl_refetch_rd", ram_rd, 1'b1);
    chk("fl_refetch_addr", ram_addr, 0);
    tick();
    chk("fl_capture_valid", chunk_valid, 1'b0);
    tick();
    pop_chk("fl_refetch");

    // Flush together with ack on an empty ring.
    wr_ptr    = 9'd1;
    flush     = 1'b1;
    chunk_ack = 1'b1;
    tick();
    flush     = 1'b0;
    chunk_ack = 1'b0;
    chk("fa_no_underrun", underrun, 1'b0);
    chk("fa_valid", chunk_valid, 1'b0);
    chk("fa_rd_ptr", rd_ptr, 0);
`ifdef CHUNK_FETCHER_UNDERRUN_CNT_EN
    chk("fa_count_cleared", underrun_count, 0);
`endif
    push(0, 1);
    tick();
    chk("fa_refetch_addr", ram_addr, 0);
    chk("fa_refetch_rd", ram_rd, 1'b1);
    tick();
    tick();
    pop_chk("fa_refetch");

    // Ack with enable low and empty ring: no underrun, no new read.
    enable    = 1'b0;
    chunk_ack = 1'b1;
    tick();
    chunk_ack = 1'b0;
    chk("dis_no_underrun", underrun, 1'b0);
    chk("dis_valid", chunk_valid, 1'b0);
    wr_ptr = 9'd2;
    tick();
    chk("dis_no_read", ram_rd, 1'b0);

    // Shrink buf_last below rd_ptr=1: the advance must wrap to 0.
    buf_last = 9'd0;
    enable   = 1'b1;
    push(1, 0);
    tick();
    chk("shrink_ram_addr", ram_addr, 1);
    chk("shrink_ram_rd", ram_rd, 1'b1);
    tick();
    tick();
    pop_chk("shrink");

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
